// File: rtl/catraca_sensor_frontend.sv
// Sensor front end for the turnstile controller: 2-flop sync, per-input debounce, passage FSM and counters.
// Optional CONTADOR_WRAP_EN: passage counters wrap instead of saturating.
module catraca_sensor_frontend #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned COUNT_W         = 8
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               giro_raw,
  input  logic               entrada_raw,
  input  logic               saida_raw,
  input  logic               metais_raw,
  output logic               giro,
  output logic               entrada,
  output logic               saida,
  output logic               metais,
  output logic               passagem_entrada,
  output logic               passagem_saida,
  output logic [COUNT_W-1:0] cont_entrada,
  output logic [COUNT_W-1:0] cont_saida,
  output logic               alarme_metal
);

  localparam logic [7:0] DB_LAST = 8'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARMED_IN  = 2'd1,
    ARMED_OUT = 2'd2,
    LOCK      = 2'd3
  } state_t;

  logic [3:0] raw_vec;
  logic [3:0] sync_a;
  logic [3:0] sync_b;
  logic [3:0] deb;
  logic [7:0] db_cnt [4];

  state_t state;
  state_t state_nxt;
  logic   done_in;
  logic   done_out;
  logic   g, e, s, m;

  assign raw_vec = {giro_raw, entrada_raw, saida_raw, metais_raw};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= raw_vec;
      sync_b <= sync_a;
    end
  end

  // Counter hitting DEBOUNCE_CYCLES-1 while still differing means this edge is the
  // DEBOUNCE_CYCLES-th differing cycle, so the output flips now.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      deb <= '0;
      for (int unsigned i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (sync_b[i] != deb[i]) begin
          if (db_cnt[i] == DB_LAST) begin
            deb[i]    <= sync_b[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + 8'd1;
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  assign g       = deb[3];
  assign e       = deb[2];
  assign s       = deb[1];
  assign m       = deb[0];
  assign giro    = g;
  assign entrada = e;
  assign saida   = s;
  assign metais  = m;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    done_in   = 1'b0;
    done_out  = 1'b0;
    case (state)
      IDLE: begin
        if (m && e)                state_nxt = LOCK;
        else if (deb == 4'b1100)   state_nxt = ARMED_IN;
        else if (g && s && !e)     state_nxt = ARMED_OUT;
      end
      ARMED_IN: begin
        if (!g)                    state_nxt = IDLE;
        else if (m)                state_nxt = LOCK;
        else if (!e && !s) begin
          state_nxt = IDLE;
          done_in   = 1'b1;
        end
      end
      ARMED_OUT: begin
        if (!g)                    state_nxt = IDLE;
        else if (!s && !e) begin
          state_nxt = IDLE;
          done_out  = 1'b1;
        end
      end
      LOCK: begin
        if (deb == 4'b0000)        state_nxt = IDLE;
      end
      default:                     state_nxt = IDLE;
    endcase
  end

  assign alarme_metal = (state == LOCK);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      passagem_entrada <= 1'b0;
      passagem_saida   <= 1'b0;
      cont_entrada     <= '0;
      cont_saida       <= '0;
    end else begin
      passagem_entrada <= done_in;
      passagem_saida   <= done_out;
`ifdef CONTADOR_WRAP_EN
      if (done_in)  cont_entrada <= cont_entrada + COUNT_W'(1);
      if (done_out) cont_saida   <= cont_saida + COUNT_W'(1);
`else
      if (done_in && (cont_entrada != '1))  cont_entrada <= cont_entrada + COUNT_W'(1);
      if (done_out && (cont_saida != '1))   cont_saida   <= cont_saida + COUNT_W'(1);
`endif
    end
  end

endmodule

// File: tb/tb_catraca_sensor_frontend.sv
// Scoreboard bench for catraca_sensor_frontend: held raw vectors (with short glitches)
// drive a reference passage model; a monitor checks every pulse against the queue.
module tb_catraca_sensor_frontend;

  localparam int CW   = 3;
  localparam int MAXC = (1 << CW) - 1;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          giro_raw = 1'b0, entrada_raw = 1'b0, saida_raw = 1'b0, metais_raw = 1'b0;
  logic          giro, entrada, saida, metais;
  logic          passagem_entrada, passagem_saida, alarme_metal;
  logic [CW-1:0] cont_entrada, cont_saida;

  int tests = 0;
  int fails = 0;
  int expq[$];
  int m_state = 0;   // 0 idle, 1 entry armed, 2 exit armed, 3 locked
  int m_ent = 0;
  int m_sai = 0;

  catraca_sensor_frontend #(
    .DEBOUNCE_CYCLES(4),
    .COUNT_W(CW)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .giro_raw(giro_raw),
    .entrada_raw(entrada_raw),
    .saida_raw(saida_raw),
    .metais_raw(metais_raw),
    .giro(giro),
    .entrada(entrada),
    .saida(saida),
    .metais(metais),
    .passagem_entrada(passagem_entrada),
    .passagem_saida(passagem_saida),
    .cont_entrada(cont_entrada),
    .cont_saida(cont_saida),
    .alarme_metal(alarme_metal)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input int actual, input int expected);
    tests++;
    if (actual != expected) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic int bump(input int c);
`ifdef CONTADOR_WRAP_EN
    return (c + 1) % (MAXC + 1);
`else
    return (c < MAXC) ? c + 1 : c;
`endif
  endfunction

  // Passage rules on a steady debounced vector; ev: 0 none, 1 entry done, 2 exit done.
  function automatic int rule(input int st, input logic [3:0] v, output int ev);
    bit gg, ee, ss, mm;
    ev = 0;
    gg = v[3]; ee = v[2]; ss = v[1]; mm = v[0];
    if (st == 0) begin
      if (mm && ee) return 3;
      if (v == 4'b1100) return 1;
      if (gg && ss && !ee) return 2;
      return 0;
    end else if (st == 1) begin
      if (!gg) return 0;
      if (mm) return 3;
      if (!ee && !ss) begin ev = 1; return 0; end
      return 1;
    end else if (st == 2) begin
      if (!gg) return 0;
      if (!ss && !ee) begin ev = 2; return 0; end
      return 2;
    end
    return (v == 4'b0000) ? 0 : 3;
  endfunction

  task automatic model_apply(input logic [3:0] v);
    int nx, ev;
    for (int k = 0; k < 4; k++) begin
      nx = rule(m_state, v, ev);
      if (ev == 1) begin m_ent = bump(m_ent); expq.push_back(1000 + m_ent); end
      if (ev == 2) begin m_sai = bump(m_sai); expq.push_back(2000 + m_sai); end
      m_state = nx;
    end
  endtask

  task automatic drive(input logic [3:0] v);
    {giro_raw, entrada_raw, saida_raw, metais_raw} = v;
  endtask

  task automatic apply(input logic [3:0] v, input bit glitch);
    logic [3:0] gv;
    int b;
    model_apply(v);
    drive(v);
    repeat (9) @(negedge clock);
    if (glitch) begin
      b  = $urandom_range(0, 3);
      gv = v;
      gv[b] = ~gv[b];
      drive(gv);
      repeat ($urandom_range(1, 3)) @(negedge clock);
      drive(v);
      repeat (9) @(negedge clock);
    end
    check("debounced_vec", int'({giro, entrada, saida, metais}), int'(v));
    check("alarme_metal", int'(alarme_metal), int'(m_state == 3));
    check("cont_entrada", int'(cont_entrada), m_ent);
    check("cont_saida", int'(cont_saida), m_sai);
  endtask

  always @(negedge clock) begin : monitor
    int got, exp_ev;
    if (reset_n && (passagem_entrada || passagem_saida)) begin
      check("one_pulse_per_cycle", int'(passagem_entrada && passagem_saida), 0);
      got = passagem_entrada ? 1000 + int'(cont_entrada) : 2000 + int'(cont_saida);
      if (expq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_pulse: got event %0d expected none at %0t", got, $time);
      end else begin
        exp_ev = expq.pop_front();
        check("pulse_event", got, exp_ev);
      end
    end
  end

  logic [3:0] pool [8] = '{4'b1100, 4'b1000, 4'b1010, 4'b0000,
                           4'b1101, 4'b0100, 4'b1110, 4'b1011};

  initial begin
    bit seen;
    int n;
    logic [3:0] v;

    repeat (3) @(negedge clock);
    check("reset_outputs", int'({giro, entrada, saida, metais, passagem_entrada, passagem_saida,
                                 alarme_metal, cont_entrada, cont_saida}), 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    // short glitch on giro must never reach the output
    seen = 0;
    giro_raw = 1'b1;
    repeat (3) @(negedge clock);
    giro_raw = 1'b0;
    repeat (12) begin
      @(negedge clock);
      if (giro) seen = 1;
    end
    check("glitch_blocked", int'(seen), 0);

    // a held edge shows up 2 sync + 4 debounce cycles later
    model_apply(4'b1000);
    giro_raw = 1'b1;
    n = 0;
    while (!giro && n < 20) begin
      @(posedge clock);
      #1;
      n++;
    end
    check("debounce_latency", n, 6);
    @(negedge clock);

    apply(4'b1100, 0); apply(4'b1000, 0);                   // entry
    apply(4'b1010, 0); apply(4'b1000, 0);                   // exit
    apply(4'b1100, 0); apply(4'b0100, 0);                   // aborted entry
    apply(4'b1101, 0); apply(4'b1000, 0); apply(4'b0000, 0); // metal lock

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0) v = 4'($urandom_range(0, 15));
      else                           v = pool[$urandom_range(0, 7)];
      apply(v, bit'($urandom_range(0, 1)));
    end

    // push both counters past all-ones
    apply(4'b0000, 0);
    for (int i = 0; i < MAXC + 2; i++) begin
      apply(4'b1100, 0); apply(4'b1000, 0);
    end
    for (int i = 0; i < MAXC + 2; i++) begin
      apply(4'b1010, 0); apply(4'b1000, 0);
    end

    // reset while armed for entry discards the passage
    apply(4'b0000, 0);
    apply(4'b1100, 0);
    reset_n = 1'b0;
    #1;
    check("async_reset_outputs", int'({giro, entrada, saida, metais, passagem_entrada, passagem_saida,
                                       alarme_metal, cont_entrada, cont_saida}), 0);
    m_state = 0; m_ent = 0; m_sai = 0;
    @(negedge clock);
    reset_n = 1'b1;
    apply(4'b1000, 0);

    check("scoreboard_drained", expq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
